regfile_sequencer: RTL and testbench

- Command-driven initiator for the 8-entry, dual-read/single-write register file.
- Accepts one register-to-register operation per valid/ready handshake.
- Drives both source selects, captures the two operands, computes the result in an internal ALU and writes it back through the write port.
- Sits between instruction decode (or a testbench) and the register file; provides the write-side stimulus the register file consumes.

---
 rtl/regfile_seq_pkg.sv | 26 ++
 rtl/seq_alu.sv | 46 ++++
 rtl/regfile_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_regfile_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_seq_pkg.sv
// Shared constants and types for the register-file sequencer.
package regfile_seq_pkg;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned SEL_W    = 3;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [2:0]       op_t;

  localparam op_t OP_ADD   = 3'b000;
  localparam op_t OP_SUB   = 3'b001;
  localparam op_t OP_AND   = 3'b010;
  localparam op_t OP_OR    = 3'b011;
  localparam op_t OP_XOR   = 3'b100;
  localparam op_t OP_MOV   = 3'b101;
  localparam op_t OP_LOADI = 3'b110;
  localparam op_t OP_NOP   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/seq_alu.sv
// Combinational W-bit ALU for the register-file sequencer.
module seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] imm_i,
  input  op_t          op_i,
  output logic [W-1:0] result_o,
  output logic         carry_o
);

  logic [W:0] sum;
  logic [W:0] diff;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  // Top bit of the widened difference is the borrow.
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = sum[W-1:0];
        carry_o  = sum[W];
      end
      OP_SUB: begin
        result_o = diff[W-1:0];
        carry_o  = diff[W];
      end
      OP_AND:   result_o = a_i & b_i;
      OP_OR:    result_o = a_i | b_i;
      OP_XOR:   result_o = a_i ^ b_i;
      OP_MOV:   result_o = a_i;
      OP_LOADI: result_o = imm_i;
      default: begin
        result_o = '0;
        carry_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Four-phase command sequencer (IDLE/FETCH/EXEC/WRITE) driving an 8-entry register file.
// Optional macro REGFILE_SEQ_ZERO_REG_EN makes register 0 read as zero and ignore writes.
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  input  logic [2:0]       Cmd_Op,
  input  logic [SEL_W-1:0] Cmd_Src0,
  input  logic [SEL_W-1:0] Cmd_Src1,
  input  logic [SEL_W-1:0] Cmd_Dst,
  input  logic [W-1:0]     Cmd_Imm,
  output logic [SEL_W-1:0] RF_Source_Select_0,
  output logic [SEL_W-1:0] RF_Source_Select_1,
  input  logic [W-1:0]     RF_Out_0,
  input  logic [W-1:0]     RF_Out_1,
  output logic [SEL_W-1:0] RF_Destination_Select,
  output logic [W-1:0]     RF_Data,
  output logic             RF_Write_Enable,
  output logic             Done,
  output logic [W-1:0]     Result,
  output logic             Carry,
  output logic             Zero
);

  state_e state_q, state_d;

  op_t          op_q, op_d;
  sel_t         sel0_q, sel0_d;
  sel_t         sel1_q, sel1_d;
  sel_t         dst_q, dst_d;
  sel_t         wsel_q, wsel_d;
  logic [W-1:0] imm_q, imm_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] res_q, res_d;
  logic [W-1:0] wdata_q, wdata_d;
  logic         carry_q, carry_d;
  logic         zero_q, zero_d;
  logic         we_q, we_d;
  logic         done_q, done_d;

  logic [W-1:0] rd0, rd1;
  logic         wr_allowed;
  logic [W-1:0] alu_res;
  logic         alu_carry;

`ifdef REGFILE_SEQ_ZERO_REG_EN
  assign rd0        = (sel0_q == '0) ? '0 : RF_Out_0;
  assign rd1        = (sel1_q == '0) ? '0 : RF_Out_1;
  assign wr_allowed = (dst_q != '0);
`else
  assign rd0        = RF_Out_0;
  assign rd1        = RF_Out_1;
  assign wr_allowed = 1'b1;
`endif

  seq_alu #(
    .W (W)
  ) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .imm_i    (imm_q),
    .op_i     (op_q),
    .result_o (alu_res),
    .carry_o  (alu_carry)
  );

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (Cmd_Valid) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next-value logic
  always_comb begin
    Cmd_Ready = (state_q == ST_IDLE);
    op_d      = op_q;
    sel0_d    = sel0_q;
    sel1_d    = sel1_q;
    dst_d     = dst_q;
    imm_d     = imm_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    wsel_d    = wsel_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Cmd_Valid) begin
          op_d   = Cmd_Op;
          sel0_d = Cmd_Src0;
          sel1_d = Cmd_Src1;
          dst_d  = Cmd_Dst;
          imm_d  = Cmd_Imm;
        end
      end
      ST_FETCH: begin
        a_d = rd0;
        b_d = rd1;
      end
      ST_EXEC: begin
        done_d = 1'b1;
        // NOP leaves result, flags and write port untouched.
        if (op_q != OP_NOP) begin
          res_d   = alu_res;
          carry_d = alu_carry;
          zero_d  = (alu_res == '0);
          wsel_d  = dst_q;
          wdata_d = alu_res;
          we_d    = wr_allowed;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      op_q    <= '0;
      sel0_q  <= '0;
      sel1_q  <= '0;
      dst_q   <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      wsel_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      op_q    <= op_d;
      sel0_q  <= sel0_d;
      sel1_q  <= sel1_d;
      dst_q   <= dst_d;
      imm_q   <= imm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      wsel_q  <= wsel_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  assign RF_Source_Select_0    = sel0_q;
  assign RF_Source_Select_1    = sel1_q;
  assign RF_Destination_Select = wsel_q;
  assign RF_Data               = wdata_q;
  assign RF_Write_Enable       = we_q;
  assign Done                  = done_q;
  assign Result                = res_q;
  assign Carry                 = carry_q;
  assign Zero                  = zero_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench: sequencer wired to a behavioural register file, checked against a model.
module tb_regfile_sequencer;

  localparam int W = 4;
  localparam int MOD = 1 << W;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR_OP = 3'd4, MOV = 3'd5, LOADI = 3'd6,
                         NOP = 3'd7;
`ifdef REGFILE_SEQ_ZERO_REG_EN
  localparam bit ZREG = 1'b1;
`else
  localparam bit ZREG = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [2:0]   cmd_op, cmd_src0, cmd_src1, cmd_dst;
  logic [W-1:0] cmd_imm;
  logic [2:0]   sel0, sel1, wsel;
  logic [W-1:0] rf_out0, rf_out1, wdata, result;
  logic         we, done, carry, zero;

  logic [W-1:0] rf [8];

  int checks = 0;
  int errors = 0;

  // Reference state
  int mrf [8];
  int exp_res = 0;
  int exp_carry = 0;
  int exp_zero = 0;

  always #5 clk = ~clk;

  regfile_sequencer #(
    .W (W)
  ) dut (
    .CLK                   (clk),
    .Reset                 (rst),
    .Cmd_Valid             (cmd_valid),
    .Cmd_Ready             (cmd_ready),
    .Cmd_Op                (cmd_op),
    .Cmd_Src0              (cmd_src0),
    .Cmd_Src1              (cmd_src1),
    .Cmd_Dst               (cmd_dst),
    .Cmd_Imm               (cmd_imm),
    .RF_Source_Select_0    (sel0),
    .RF_Source_Select_1    (sel1),
    .RF_Out_0              (rf_out0),
    .RF_Out_1              (rf_out1),
    .RF_Destination_Select (wsel),
    .RF_Data               (wdata),
    .RF_Write_Enable       (we),
    .Done                  (done),
    .Result                (result),
    .Carry                 (carry),
    .Zero                  (zero)
  );

  always_ff @(posedge clk) if (we) rf[wsel] <= wdata;
  assign rf_out0 = rf[sel0];
  assign rf_out1 = rf[sel1];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Architectural effect of one command; updates model registers and flags.
  task automatic model_cmd(input logic [2:0] op, input int s0, input int s1, input int d,
                           input int imm, output int r, output bit wr);
    int a, b, c;
    a = (ZREG && s0 == 0) ? 0 : mrf[s0];
    b = (ZREG && s1 == 0) ? 0 : mrf[s1];
    c = 0;
    case (op)
      3'd0: begin r = (a + b) % MOD; c = (a + b >= MOD) ? 1 : 0; end
      3'd1: begin r = (a - b + MOD) % MOD; c = (a < b) ? 1 : 0; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a;
      3'd6: r = imm;
      default: r = exp_res;
    endcase
    wr = (op != NOP) && !(ZREG && d == 0);
    if (op != NOP) begin
      exp_res = r;
      exp_carry = c;
      exp_zero = (r == 0) ? 1 : 0;
    end
    if (wr) mrf[d] = r;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_cmd", cmd_ready, 1);
  endtask

  task automatic check_rf();
    for (int i = (ZREG ? 1 : 0); i < 8; i++) check($sformatf("rf[%0d]", i), rf[i], mrf[i]);
  endtask

  // One command with valid dropped after the handshake; checks every phase.
  task automatic issue(input logic [2:0] op, input logic [2:0] s0, input logic [2:0] s1,
                       input logic [2:0] d, input logic [W-1:0] imm);
    int r;
    bit wr;
    wait_ready();
    model_cmd(op, s0, s1, d, imm, r, wr);
    cmd_valid = 1'b1;
    cmd_op = op; cmd_src0 = s0; cmd_src1 = s1; cmd_dst = d; cmd_imm = imm;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_src0 = 3'($urandom); cmd_src1 = 3'($urandom);
    cmd_dst = 3'($urandom); cmd_imm = W'($urandom);
    check("fetch_sel0", sel0, s0);
    check("fetch_sel1", sel1, s1);
    check("fetch_ready", cmd_ready, 0);
    check("fetch_we", we, 0);
    check("fetch_done", done, 0);
    @(negedge clk);
    check("exec_we", we, 0);
    check("exec_done", done, 0);
    @(negedge clk);
    check("write_we", we, wr);
    check("write_done", done, 1);
    if (wr) begin
      check("write_dst", wsel, d);
      check("write_data", wdata, r);
    end
    check("result", result, exp_res);
    check("carry", carry, exp_carry);
    check("zero", zero, exp_zero);
    @(negedge clk);
    check("idle_we", we, 0);
    check("idle_done", done, 0);
    check("idle_ready", cmd_ready, 1);
    if (wr) check("rf_dst", rf[d], r);
  endtask

  // Three commands with valid held high throughout.
  task automatic burst(input bit nop2);
    logic [2:0] ops [3], s0 [3], s1 [3], ds [3];
    logic [W-1:0] ims [3];
    int er [3];
    int r, wr_cnt = 0, we_cnt = 0, done_cnt = 0, idx = 0;
    bit wr;
    for (int i = 0; i < 3; i++) begin
      ops[i] = 3'($urandom_range(0, 6));
      s0[i] = 3'($urandom); s1[i] = 3'($urandom); ds[i] = 3'($urandom_range(1, 7));
      ims[i] = W'($urandom);
    end
    if (nop2) ops[1] = NOP;
    wait_ready();
    for (int i = 0; i < 3; i++) begin
      model_cmd(ops[i], s0[i], s1[i], ds[i], ims[i], r, wr);
      er[i] = exp_res;
      if (wr) wr_cnt++;
    end
    for (int n = 0; n < 12; n++) begin
      check("burst_ready", cmd_ready, (n % 4 == 0) ? 1 : 0);
      if (we) we_cnt++;
      if (done) begin
        check("burst_result", result, er[done_cnt]);
        done_cnt++;
      end
      if (cmd_ready && idx < 3) begin
        cmd_valid = 1'b1;
        cmd_op = ops[idx]; cmd_src0 = s0[idx]; cmd_src1 = s1[idx];
        cmd_dst = ds[idx]; cmd_imm = ims[idx];
        idx++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("burst_ready_end", cmd_ready, 1);
    check("burst_we_pulses", we_cnt, wr_cnt);
    check("burst_done_pulses", done_cnt, 3);
    check("burst_carry", carry, exp_carry);
    check("burst_zero", zero, exp_zero);
    check_rf();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int prior7, we_seen;
    for (int i = 0; i < 8; i++) mrf[i] = 0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0; cmd_src0 = '0; cmd_src1 = '0; cmd_dst = '0; cmd_imm = '0;
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_we", we, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {carry, zero}, 0);
    check("rst_sels", {sel0, sel1, wsel}, 0);
    check("rst_data", wdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Give every register a known value.
    for (int i = 0; i < 8; i++) issue(LOADI, 3'($urandom), 3'($urandom), 3'(i), W'($urandom));

    issue(LOADI, 3'd0, 3'd0, 3'd1, 4'd9);
    issue(LOADI, 3'd0, 3'd0, 3'd2, 4'd8);
    issue(ADD, 3'd1, 3'd2, 3'd3, 4'd0);
    check("add_r3", rf[3], 1);
    check("add_carry", carry, 1);
    issue(SUB, 3'd2, 3'd1, 3'd4, 4'd0);
    check("sub_r4", rf[4], 15);
    check("sub_borrow", carry, 1);
    issue(SUB, 3'd1, 3'd2, 3'd5, 4'd0);
    check("sub_r5", rf[5], 1);
    check("sub_noborrow", carry, 0);
    issue(XOR_OP, 3'd1, 3'd1, 3'd1, 4'd0);
    check("xor_zero", zero, 1);
    issue(MOV, 3'd1, 3'd0, 3'd6, 4'd0);
    check("mov_raw_r6", rf[6], 0);

    burst(1'b0);
    burst(1'b1);

    for (int i = 0; i < 24; i++)
      issue(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), W'($urandom));
    check_rf();

`ifdef REGFILE_SEQ_ZERO_REG_EN
    issue(LOADI, 3'd0, 3'd0, 3'd0, 4'd5);
    check("zr_result", result, 5);
    issue(MOV, 3'd0, 3'd0, 3'd2, 4'd0);
    check("zr_r2", rf[2], 0);
`endif

    // Reset during EXEC aborts the pending write.
    prior7 = mrf[7];
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op = ADD; cmd_src0 = 3'd3; cmd_src1 = 3'd4; cmd_dst = 3'd7; cmd_imm = '0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", cmd_ready, 1);
    check("abort_we", we, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_flags", {carry, zero}, 0);
    check("abort_sels", {sel0, sel1, wsel}, 0);
    check("abort_data", wdata, 0);
    we_seen = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (we || done) we_seen++;
    end
    rst = 1'b0;
    exp_res = 0; exp_carry = 0; exp_zero = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (we || done) we_seen++;
    end
    check("abort_no_pulse", we_seen, 0);
    check("abort_r7", rf[7], prior7);
    check("abort_ready_after", cmd_ready, 1);

    issue(ADD, 3'($urandom), 3'($urandom), 3'd7, 4'd0);
    check_rf();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
